// File: rtl/power_activity_monitor.sv
// ---------------------------------------------------------------------------
// power_activity_monitor : windowed toggle-activity and watch-value trust monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module power_activity_monitor #(
  parameter int          MON_W     = 128,
  parameter int          WIN_LEN   = 256,
  parameter int          CNT_W     = 16,
  parameter int          HOT_WINS  = 4,
  parameter logic [63:0] WATCH_VAL = 64'h0011223344556677
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [63:0]      state,
  input  logic [MON_W-1:0] mon_bus,
  input  logic [CNT_W-1:0] threshold,
  input  logic             alarm_clr,
  output logic             alarm,
  output logic             watch_hit,
  output logic             win_done,
  output logic [CNT_W-1:0] last_count,
  output logic [3:0]       hot_streak
);

  localparam int TOG_W = $clog2(MON_W + 1);
  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       HOT_LIM  = 4'(HOT_WINS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MONITOR = 2'd1;
  localparam logic [1:0] S_SUSPECT = 2'd2;
  localparam logic [1:0] S_ALARM   = 2'd3;

  function automatic logic [TOG_W-1:0] popcount(input logic [MON_W-1:0] v);
    logic [TOG_W-1:0] n;
    n = '0;
    for (int i = 0; i < MON_W; i++) begin
      n = n + TOG_W'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]       fsm_state;
  logic [1:0]       fsm_next;
  logic             counting;
  logic [MON_W-1:0] prev;
  logic             prev_valid;
  logic [CNT_W-1:0] acc;
  logic [WIN_W-1:0] win_cnt;
  logic [TOG_W-1:0] tog;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] tot;
  logic             win_end;
  logic             win_hot;
  logic             hot_end;
  logic [3:0]       streak_inc;
  logic             reach;

  // First counted cycle after IDLE/reset has no valid history, so its toggles are masked.
  assign tog        = (counting && prev_valid) ? popcount(mon_bus ^ prev) : '0;
  assign sum        = {1'b0, acc} + (CNT_W + 1)'(tog);
  assign tot        = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  assign win_end    = counting && (win_cnt == WIN_LAST);
  assign win_hot    = tot > threshold;
  assign hot_end    = win_end && win_hot && !alarm_clr;
  assign streak_inc = (hot_streak == 4'hF) ? 4'hF : hot_streak + 4'd1;
  assign reach      = streak_inc >= HOT_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= S_IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_state;
    if (!enable) begin
      fsm_next = S_IDLE;
    end else begin
      case (fsm_state)
        S_IDLE:    fsm_next = S_MONITOR;
        S_MONITOR: begin
          if (hot_end) fsm_next = reach ? S_ALARM : S_SUSPECT;
        end
        S_SUSPECT: begin
          if (alarm_clr)             fsm_next = S_MONITOR;
          else if (hot_end && reach) fsm_next = S_ALARM;
          else if (win_end && !win_hot) fsm_next = S_MONITOR;
        end
        S_ALARM: begin
          if (alarm_clr) fsm_next = S_MONITOR;
        end
        default:   fsm_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    counting = 1'b0;
    if (enable && (fsm_state != S_IDLE)) counting = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      acc        <= '0;
      win_cnt    <= '0;
      win_done   <= 1'b0;
      last_count <= '0;
    end else begin
      prev     <= mon_bus;
      win_done <= 1'b0;
      if (counting) begin
        prev_valid <= 1'b1;
        if (win_end) begin
          acc        <= '0;
          win_cnt    <= '0;
          last_count <= tot;
          win_done   <= 1'b1;
        end else begin
          acc     <= tot;
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end else begin
        // Leaving the counting states abandons the partial window.
        acc        <= '0;
        win_cnt    <= '0;
        prev_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm      <= 1'b0;
      watch_hit  <= 1'b0;
      hot_streak <= 4'd0;
    end else if (alarm_clr) begin
      alarm      <= 1'b0;
      watch_hit  <= 1'b0;
      hot_streak <= 4'd0;
    end else begin
      if (state == WATCH_VAL) watch_hit <= 1'b1;
      if (win_end) begin
        if (win_hot) begin
          hot_streak <= streak_inc;
          if (reach) alarm <= 1'b1;
        end else begin
          hot_streak <= 4'd0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_power_activity_monitor.sv
// ---------------------------------------------------------------------------
// tb_power_activity_monitor : directed stimulus, cycle model and literal pins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_power_activity_monitor;

  localparam int          MON_W    = 128;
  localparam int          WIN_LEN  = 256;
  localparam int          CNT_W    = 16;
  localparam int          HOT_WINS = 4;
  localparam logic [63:0] WATCH    = 64'h0011223344556677;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [63:0]      state;
  logic [MON_W-1:0] mon_bus;
  logic [CNT_W-1:0] threshold;
  logic             alarm_clr;
  logic             alarm;
  logic             watch_hit;
  logic             win_done;
  logic [CNT_W-1:0] last_count;
  logic [3:0]       hot_streak;

  power_activity_monitor #(
    .MON_W(MON_W), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .HOT_WINS(HOT_WINS), .WATCH_VAL(WATCH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .state(state), .mon_bus(mon_bus),
    .threshold(threshold), .alarm_clr(alarm_clr), .alarm(alarm), .watch_hit(watch_hit),
    .win_done(win_done), .last_count(last_count), .hot_streak(hot_streak)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit hot      = 1'b0;

  // Model: monitoring is live on a cycle iff enable is high now and was high at the previous edge.
  bit             m_en_prev, m_pv, m_alarm, m_watch, m_wd;
  logic [MON_W-1:0] m_prev;
  int             m_acc, m_wc, m_streak, m_last;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_en_prev = 0; m_pv = 0; m_alarm = 0; m_watch = 0; m_wd = 0;
    m_prev = '0; m_acc = 0; m_wc = 0; m_streak = 0; m_last = 0;
  endfunction

  function automatic void model_step();
    bit live;
    int tog, tot;
    live = enable && m_en_prev;
    tog  = (live && m_pv) ? $countones(mon_bus ^ m_prev) : 0;
    m_wd = 0;
    if (live) begin
      tot = m_acc + tog;
      if (tot > 65535) tot = 65535;
      if (m_wc == WIN_LEN - 1) begin
        m_last = tot; m_wd = 1; m_acc = 0; m_wc = 0;
        if (!alarm_clr) begin
          if (tot > int'(threshold)) begin
            if (m_streak < 15) m_streak++;
            if (m_streak == HOT_WINS) m_alarm = 1;
          end else begin
            m_streak = 0;
          end
        end
      end else begin
        m_acc = tot; m_wc++;
      end
      m_pv = 1;
    end else begin
      m_acc = 0; m_wc = 0; m_pv = 0;
    end
    if (alarm_clr) begin
      m_alarm = 0; m_watch = 0; m_streak = 0;
    end else if (state == WATCH) begin
      m_watch = 1;
    end
    m_prev    = mon_bus;
    m_en_prev = enable;
  endfunction

  function automatic void compare_all();
    chk("alarm",      alarm,      m_alarm);
    chk("watch_hit",  watch_hit,  m_watch);
    chk("win_done",   win_done,   m_wd);
    chk("last_count", last_count, m_last);
    chk("hot_streak", hot_streak, m_streak);
  endfunction

  task automatic tick();
    if (hot) mon_bus = ~mon_bus;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; alarm_clr = 1'b0; state = '0; threshold = '0;
    mon_bus = {32{4'hA}};
    do_reset();
    chk("rst_alarm", alarm, 0);
    chk("rst_last",  last_count, 0);

    // Quiet bus, threshold 0: a zero total equals the threshold and stays cold.
    enable = 1'b1; threshold = 16'd0; hot = 1'b0;
    tick();
    for (int w = 0; w < 3; w++) begin
      run(255);
      chk("t1_no_early_done", win_done, 0);
      run(1);
      chk("t1_done", win_done, 1);
      chk("t1_last", last_count, 0);
      chk("t1_alarm", alarm, 0);
    end

    // Full toggling; the first window loses its masked first cycle (255*128).
    do_reset();
    enable = 1'b1; threshold = 16'd1000; hot = 1'b1;
    tick();
    for (int w = 1; w <= 4; w++) begin
      run(256);
      chk("t2_last", last_count, (w == 1) ? 32640 : 32768);
      chk("t2_streak", hot_streak, w);
      chk("t2_alarm", alarm, (w == 4) ? 1 : 0);
    end
    threshold = 16'd32768;
    run(256);
    chk("t2_equal_is_cold", hot_streak, 0);
    chk("t2_alarm_sticky", alarm, 1);

    // Hot x3, quiet, hot x4.
    do_reset();
    enable = 1'b1; threshold = 16'd1000; hot = 1'b1;
    tick();
    run(3 * 256);
    chk("t3_streak3", hot_streak, 3);
    hot = 1'b0;
    run(256);
    chk("t3_quiet_streak", hot_streak, 0);
    chk("t3_quiet_last", last_count, 0);
    hot = 1'b1;
    run(3 * 256);
    chk("t3_no_alarm_yet", alarm, 0);
    run(256);
    chk("t3_alarm", alarm, 1);
    chk("t3_streak4", hot_streak, 4);

    // Enable drop at win_cnt=100: window abandoned, results held.
    run(100);
    enable = 1'b0;
    run(20);
    chk("t6_held_last", last_count, 32768);
    chk("t6_held_alarm", alarm, 1);
    enable = 1'b1;
    tick();
    run(255);
    chk("t6_no_short_done", win_done, 0);
    run(1);
    chk("t6_done", win_done, 1);
    chk("t6_last_masked", last_count, 32640);
    state = WATCH;
    tick();
    state = '0;
    chk("t6_watch", watch_hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_alarm", alarm, 0);
    chk("t6_async_watch", watch_hit, 0);
    chk("t6_async_last", last_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Watch value while disabled; a near-miss value must not match.
    enable = 1'b0; hot = 1'b0;
    state = WATCH ^ 64'd1;
    tick();
    chk("t4_near_miss", watch_hit, 0);
    state = WATCH;
    tick();
    state = '0;
    chk("t4_watch", watch_hit, 1);
    run(10);
    chk("t4_watch_sticky", watch_hit, 1);

    // alarm_clr coincident with the 4th hot window end and a watch match.
    enable = 1'b1; threshold = 16'd1000; hot = 1'b1;
    tick();
    run(3 * 256 + 255);
    alarm_clr = 1'b1; state = WATCH;
    tick();
    alarm_clr = 1'b0; state = '0;
    chk("t5_alarm", alarm, 0);
    chk("t5_streak", hot_streak, 0);
    chk("t5_watch", watch_hit, 0);
    chk("t5_done", win_done, 1);
    chk("t5_last", last_count, 32768);
    run(256);
    chk("t5_restart_streak", hot_streak, 1);
    chk("t5_restart_alarm", alarm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
